// File: rtl/rsa_frame_pkg.sv
// ---------------------------------------------------------------------------
// rsa_frame_pkg
// Shared definitions for the RSA result transmit framer (frame_tx) and its
// UART byte handshake helper.
//   SOF       : start-of-frame byte that opens every packet
//   state_e   : state encoding shared by the framer and the handshake FSM
//   cnt_width : width of the per-frame byte index for a given data length
// ---------------------------------------------------------------------------
package rsa_frame_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    WAIT_START,
    WAIT_DONE
  } state_e;

  // Index runs 0..NBYTES+2 at most (SOF, length, data, checksum), so the
  // counter never has to wrap inside a frame.
  function automatic int cnt_width(input int nbytes);
    return $clog2(nbytes + 3);
  endfunction

endpackage

// File: rtl/frame_tx_if.sv
// ---------------------------------------------------------------------------
// frame_tx_if
// Bundles the result-capture inputs, the UART byte interface and the status
// outputs of frame_tx.
//   rx_valid/rx_bytes : one-cycle capture strobe and the N-bit result word
//   is_transmitting   : UART line busy
//   tx_byte/tx_valid  : byte and one-cycle transmit pulse to the UART
//   busy/drop         : frame in progress / rejected capture pulse
// Modports: master = word source plus UART (the environment),
//           slave  = frame_tx.
// ---------------------------------------------------------------------------
interface frame_tx_if #(
  parameter int N = 256
);
  logic         rx_valid;
  logic [N-1:0] rx_bytes;
  logic         is_transmitting;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         busy;
  logic         drop;

  modport master (
    output rx_valid, rx_bytes, is_transmitting,
    input  tx_byte, tx_valid, busy, drop
  );

  modport slave (
    input  rx_valid, rx_bytes, is_transmitting,
    output tx_byte, tx_valid, busy, drop
  );
endinterface

// File: rtl/uart_byte_handshake.sv
// ---------------------------------------------------------------------------
// uart_byte_handshake
// Hands one byte to the UART transmitter and reports when the line is free
// again. A go strobe latches byte_in and raises tx_valid for one cycle, then
// the block waits for is_transmitting to rise (at most START_WAIT cycles, so
// a UART that flags busy late or never cannot stall the frame) and to fall.
//   clk, rst        : clock, synchronous active-high reset
//   go, byte_in     : request to send byte_in (accepted only when idle)
//   is_transmitting : UART line busy
//   tx_byte         : byte presented to the UART, held until the next go
//   tx_valid        : one-cycle transmit pulse
//   done            : one-cycle strobe, the byte has left the line
// ---------------------------------------------------------------------------
module uart_byte_handshake
  import rsa_frame_pkg::*;
#(
  parameter int START_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] byte_in,
  input  logic       is_transmitting,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic       done
);

  localparam int TW = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_valid_q, tx_valid_d;

  // Combinational so the framer advances on the same edge this FSM idles.
  assign done = (state_q == WAIT_DONE) && !is_transmitting;

  always_comb begin
    // NOTE: every signal gets a default before the case; otherwise any path
    // that skips an assignment infers a latch.
    state_d    = state_q;
    timer_d    = timer_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = PULSE;
          tx_byte_d  = byte_in;
          tx_valid_d = 1'b1;
        end
      end
      PULSE: begin
        state_d = WAIT_START;
        timer_d = '0;
      end
      WAIT_START: begin
        if (is_transmitting || timer_q == TW'(START_WAIT - 1)) begin
          state_d = WAIT_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch
    // inside the clocked block; it never appears in the sensitivity list.
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: rtl/frame_tx.sv
// ---------------------------------------------------------------------------
// frame_tx
// Transmit-side framer for RSA results. Captures one N-bit answer word and
// sends it through the UART byte transmitter as
//   SOF, NBYTES, data bytes MSB first [, XOR checksum]
// The checksum covers the length byte and the data bytes, not SOF.
// Build option: define FRAME_CHECKSUM_EN to append the checksum byte; when
// undefined the last data byte ends the frame and no checksum logic exists.
//   clk, rst : clock, synchronous active-high reset
//   bus      : frame_tx_if.slave (rx_valid, rx_bytes, is_transmitting in;
//              tx_byte, tx_valid, busy, drop out)
// ---------------------------------------------------------------------------
module frame_tx
  import rsa_frame_pkg::*;
#(
  parameter int N          = 256,
  parameter int START_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  frame_tx_if.slave  bus
);

  localparam int NBYTES = N / 8;
  localparam int CW     = cnt_width(NBYTES);
`ifdef FRAME_CHECKSUM_EN
  localparam int LAST_IDX = NBYTES + 2;
`else
  localparam int LAST_IDX = NBYTES + 1;
`endif

  state_e         state_q, state_d;
  logic [N-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [7:0]     cur_byte_q, cur_byte_d;
  logic           go_q, go_d;
  logic           busy_q, busy_d;
  logic           drop_q, drop_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif

  logic           hs_done;
  logic [7:0]     hs_tx_byte;
  logic           hs_tx_valid;

  uart_byte_handshake #(
    .START_WAIT (START_WAIT)
  ) u_handshake (
    .clk             (clk),
    .rst             (rst),
    .go              (go_q),
    .byte_in         (cur_byte_q),
    .is_transmitting (bus.is_transmitting),
    .tx_byte         (hs_tx_byte),
    .tx_valid        (hs_tx_valid),
    .done            (hs_done)
  );

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    idx_d      = idx_q;
    cur_byte_d = cur_byte_q;
    busy_d     = busy_q;
    go_d       = 1'b0;
    // Any capture attempt while a frame is running (including the cycle in
    // which busy falls) is rejected and flagged.
    drop_d     = bus.rx_valid && busy_q;
`ifdef FRAME_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          sreg_d  = bus.rx_bytes;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = LOAD;
`ifdef FRAME_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LOAD: begin
        if (idx_q == CW'(0)) begin
          cur_byte_d = SOF;
        end else if (idx_q == CW'(1)) begin
          cur_byte_d = 8'(NBYTES);
        end else if (idx_q <= CW'(NBYTES + 1)) begin
          cur_byte_d = sreg_q[N-1 -: 8];
          sreg_d     = sreg_q << 8;
        end
`ifdef FRAME_CHECKSUM_EN
        else begin
          cur_byte_d = csum_q;
        end
`endif
        go_d    = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (hs_done) begin
`ifdef FRAME_CHECKSUM_EN
          if (idx_q != CW'(0) && idx_q <= CW'(NBYTES + 1)) begin
            csum_d = csum_q ^ cur_byte_q;
          end
`endif
          if (idx_q == CW'(LAST_IDX)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      idx_q      <= '0;
      cur_byte_q <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      idx_q      <= idx_d;
      cur_byte_q <= cur_byte_d;
      go_q       <= go_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.tx_byte  = hs_tx_byte;
  assign bus.tx_valid = hs_tx_valid;
  assign bus.busy     = busy_q;
  assign bus.drop     = drop_q;

endmodule

// File: tb/tb_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_frame_tx
// Drives an N=16 and an N=256 frame_tx with fixed and $urandom result words
// and compares the emitted byte stream against a frame built directly from
// the packet format. A small UART model raises is_transmitting one cycle
// after each pulse and holds it 10 cycles, or never raises it.
// ---------------------------------------------------------------------------
module tb_frame_tx;

  localparam int START_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_tx_if #(.N(16))  if16 ();
  frame_tx_if #(.N(256)) if256 ();

  frame_tx #(.N(16),  .START_WAIT(START_WAIT)) dut16  (.clk(clk), .rst(rst), .bus(if16));
  frame_tx #(.N(256), .START_WAIT(START_WAIT)) dut256 (.clk(clk), .rst(rst), .bus(if256));

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q16[$];
  logic [7:0] q256[$];
  logic [7:0] exp_q[$];
  int         t16[$];
  int         cyc = 0;
  int         drops16 = 0;

  // UART models
  logic never16 = 1'b0;
  logic pend16 = 1'b0, pend256 = 1'b0;
  int   left16 = 0, left256 = 0;
  logic uart16_busy = 1'b0, uart256_busy = 1'b0;
  assign if16.is_transmitting  = uart16_busy;
  assign if256.is_transmitting = uart256_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if16.tx_valid) begin
      q16.push_back(if16.tx_byte);
      t16.push_back(cyc);
    end
    if (if16.drop) drops16 <= drops16 + 1;
    if (if256.tx_valid) q256.push_back(if256.tx_byte);
  end

  always @(negedge clk) begin
    if (pend16) begin
      pend16 <= 1'b0;
      if (!never16) begin
        uart16_busy <= 1'b1;
        left16      <= 10;
      end
    end else if (left16 > 0) begin
      left16 <= left16 - 1;
      if (left16 == 1) uart16_busy <= 1'b0;
    end
    if (if16.tx_valid) pend16 <= 1'b1;
  end

  always @(negedge clk) begin
    if (pend256) begin
      pend256      <= 1'b0;
      uart256_busy <= 1'b1;
      left256      <= 10;
    end else if (left256 > 0) begin
      left256 <= left256 - 1;
      if (left256 == 1) uart256_busy <= 1'b0;
    end
    if (if256.tx_valid) pend256 <= 1'b1;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: SOF, length, data bytes MSB first, optional XOR of
  // length and data.
  function automatic void model(int nbytes, logic [255:0] word);
    logic [7:0] b;
    logic [7:0] cs;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(nbytes));
    cs = 8'(nbytes);
    for (int k = 0; k < nbytes; k++) begin
      b = 8'(word >> (8 * (nbytes - 1 - k)));
      exp_q.push_back(b);
      cs = cs ^ b;
    end
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction

  task automatic compare(string tag, input logic [7:0] got[$]);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic wait_idle(int which, string tag);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (which == 0 && !if16.busy) return;
      if (which == 1 && !if256.busy) return;
    end
    check({tag, "_idle_timeout"}, 1, 0);
  endtask

  task automatic wait_bytes16(int n, string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (q16.size() >= n) return;
    end
    check({tag, "_bytes_timeout"}, q16.size(), n);
  endtask

  // Drive a capture strobe sampled by the next rising edge; returns 1 time
  // unit after that edge.
  task automatic pulse16(logic [15:0] w);
    @(negedge clk);
    if16.rx_bytes = w;
    if16.rx_valid = 1'b1;
    @(posedge clk);
    #1 if16.rx_valid = 1'b0;
  endtask

  task automatic pulse256(logic [255:0] w);
    @(negedge clk);
    if256.rx_bytes = w;
    if256.rx_valid = 1'b1;
    @(posedge clk);
    #1 if256.rx_valid = 1'b0;
  endtask

  task automatic send16(logic [15:0] w, string tag);
    q16.delete();
    t16.delete();
    model(2, {240'b0, w});
    pulse16(w);
    check({tag, "_busy"}, if16.busy, 1);
    wait_idle(0, tag);
    compare(tag, q16);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  w16;
    logic [255:0] w256;
    int           d0;
    int           gap;

    if16.rx_valid  = 1'b0;
    if16.rx_bytes  = '0;
    if256.rx_valid = 1'b0;
    if256.rx_bytes = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", if16.busy, 0);
    check("rst_tx_valid", if16.tx_valid, 0);
    check("rst_drop", if16.drop, 0);
    check("rst_tx_byte", if16.tx_byte, 0);
    check("rst_busy256", if256.busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame with latency check: SOF pulse two edges after capture
    q16.delete();
    t16.delete();
    model(2, {240'b0, 16'h1234});
    pulse16(16'h1234);
    check("cap_busy", if16.busy, 1);
    @(posedge clk);
    #1 check("lat_t1_valid", if16.tx_valid, 0);
    @(posedge clk);
    #1 check("lat_t2_valid", if16.tx_valid, 1);
    check("lat_t2_byte", if16.tx_byte, 8'hA5);
    wait_idle(0, "f1234");
    compare("f1234", q16);

    // Capture attempt during data byte 0x12 is dropped, frame unaffected
    q16.delete();
    d0 = drops16;
    model(2, {240'b0, 16'h1234});
    pulse16(16'h1234);
    wait_bytes16(3, "drop");
    pulse16(16'hFFFF);
    check("drop_pulse", if16.drop, 1);
    @(posedge clk);
    #1 check("drop_one_cycle", if16.drop, 0);
    wait_idle(0, "drop");
    compare("drop_frame", q16);
    check("drop_count", drops16 - d0, 1);
    send16(16'hFFFF, "fFFFF");

    // Capture held through the edge where busy falls must be dropped
    q16.delete();
    model(2, {240'b0, 16'h0F0F});
    pulse16(16'h0F0F);
    wait_bytes16(exp_q.size(), "edge");
    if16.rx_bytes = 16'h7777;
    if16.rx_valid = 1'b1;
    for (int i = 0; i < 200 && if16.busy; i++) @(negedge clk);
    if16.rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("edge_no_restart", if16.busy, 0);
    compare("edge_frame", q16);

    // UART never flags busy: bytes still advance after the start timeout
    @(negedge clk);
    never16 = 1'b1;
    w16 = 16'($urandom());
    send16(w16, "never");
    for (int i = 1; i < t16.size(); i++) begin
      gap = t16[i] - t16[i-1];
      check($sformatf("never_gap%0d", i),
            (gap >= START_WAIT + 2 && gap <= START_WAIT + 8), 1);
    end
    @(negedge clk);
    never16 = 1'b0;

    // Reset while the length byte is on the line aborts the frame
    q16.delete();
    pulse16(16'h5A3C);
    wait_bytes16(2, "rst");
    repeat (4) @(negedge clk);
    check("rst_mid_uart_busy", uart16_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_busy", if16.busy, 0);
    check("rst_mid_tx_valid", if16.tx_valid, 0);
    check("rst_mid_drop", if16.drop, 0);
    @(negedge clk);
    rst = 1'b0;
    send16(16'hABCD, "fABCD");

    // Random words with random idle gaps
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      w16 = 16'($urandom());
      send16(w16, $sformatf("rand%0d", r));
    end

    // Wide word: bytes 0x01..0x20 MSB first
    w256 = '0;
    for (int k = 0; k < 32; k++) w256[255 - 8*k -: 8] = 8'(k + 1);
    q256.delete();
    model(32, w256);
    pulse256(w256);
    check("w256_busy", if256.busy, 1);
    wait_idle(1, "w256");
    compare("w256", q256);

    for (int i = 0; i < 8; i++) w256[32*i +: 32] = $urandom();
    q256.delete();
    model(32, w256);
    pulse256(w256);
    wait_idle(1, "r256");
    compare("r256", q256);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
